// File: rtl/tl_cpl_tx_packer.sv
// Completion TX packer: serializes a 3DW completion header plus optional payload
// beats into a 256-bit TX beat stream. Optional statistics under TL_CPL_TX_STATS_EN.
module tl_cpl_tx_packer #(
  parameter int MAX_PAYLOAD_DW = 256,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [127:0]     cpl_hdr_i,
  input  logic             cpl_hdr_valid_i,
  output logic             cpl_hdr_ready_o,
  input  logic [255:0]     cpl_data_i,
  input  logic             cpl_data_valid_i,
  output logic             cpl_data_ready_o,
  output logic [255:0]     tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             tx_sop_o,
  output logic             tx_eop_o,
  output logic [7:0]       tx_dw_en_o,
  output logic             hdr_cred_consume_o,
  output logic             data_cred_consume_o,
  output logic [8:0]       data_cred_cnt_o,
  output logic             len_err_o,
  output logic [CNT_W-1:0] cpl_cnt_o,
  output logic [CNT_W-1:0] cpld_cnt_o
);

  typedef enum logic [0:0] {S_IDLE, S_DATA} state_e;

  state_e       state_q, state_d;
  logic [10:0]  rem_q, rem_d;
  logic [255:0] tx_data_q, tx_data_d;
  logic         tx_valid_q, tx_valid_d;
  logic         sop_q, sop_d;
  logic         eop_q, eop_d;
  logic [7:0]   dw_en_q, dw_en_d;
  logic         hdr_cred_q, hdr_cred_d;
  logic         data_cred_q, data_cred_d;
  logic [8:0]   data_cred_cnt_q, data_cred_cnt_d;
  logic         len_err_q, len_err_d;

  logic         adv;
  logic         hdr_fire;
  logic         data_fire;
  logic         hdr_has_data;
  logic [10:0]  hdr_len;
  logic [10:0]  hdr_len_rnd;

  assign adv              = !tx_valid_q || tx_ready_i;
  assign cpl_hdr_ready_o  = (state_q == S_IDLE) && adv;
  assign cpl_data_ready_o = (state_q == S_DATA) && adv;
  assign hdr_fire         = cpl_hdr_valid_i && cpl_hdr_ready_o;
  assign data_fire        = cpl_data_valid_i && cpl_data_ready_o;

  // Length field of 0 encodes 1024 DW, hence the 11-bit remaining count.
  assign hdr_has_data = cpl_hdr_i[126];
  assign hdr_len      = (cpl_hdr_i[105:96] == 10'd0) ? 11'd1024 : {1'b0, cpl_hdr_i[105:96]};
  assign hdr_len_rnd  = hdr_len + 11'd3;

  always_comb begin
    state_d         = state_q;
    rem_d           = rem_q;
    tx_data_d       = tx_data_q;
    tx_valid_d      = tx_valid_q;
    sop_d           = sop_q;
    eop_d           = eop_q;
    dw_en_d         = dw_en_q;
    hdr_cred_d      = 1'b0;
    data_cred_d     = 1'b0;
    data_cred_cnt_d = 9'd0;
    len_err_d       = 1'b0;

    // Sink took the current beat (or slot empty) and nothing replaces it.
    if (adv) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (hdr_fire) begin
          tx_data_d  = {cpl_hdr_i[127:32], 160'd0};
          tx_valid_d = 1'b1;
          sop_d      = 1'b1;
          eop_d      = !hdr_has_data;
          dw_en_d    = 8'hE0;
          hdr_cred_d = 1'b1;
          if (hdr_has_data) begin
            data_cred_d     = 1'b1;
            data_cred_cnt_d = hdr_len_rnd[10:2];
            rem_d           = hdr_len;
            len_err_d       = (int'(hdr_len) > MAX_PAYLOAD_DW);
            state_d         = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (data_fire) begin
          tx_data_d  = cpl_data_i;
          tx_valid_d = 1'b1;
          sop_d      = 1'b0;
          dw_en_d    = (rem_q >= 11'd8) ? 8'hFF : ~(8'hFF >> rem_q[2:0]);
          eop_d      = (rem_q <= 11'd8);
          rem_d      = (rem_q > 11'd8) ? (rem_q - 11'd8) : 11'd0;
          if (rem_q <= 11'd8) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      rem_q           <= 11'd0;
      tx_data_q       <= 256'd0;
      tx_valid_q      <= 1'b0;
      sop_q           <= 1'b0;
      eop_q           <= 1'b0;
      dw_en_q         <= 8'd0;
      hdr_cred_q      <= 1'b0;
      data_cred_q     <= 1'b0;
      data_cred_cnt_q <= 9'd0;
      len_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      rem_q           <= rem_d;
      tx_data_q       <= tx_data_d;
      tx_valid_q      <= tx_valid_d;
      sop_q           <= sop_d;
      eop_q           <= eop_d;
      dw_en_q         <= dw_en_d;
      hdr_cred_q      <= hdr_cred_d;
      data_cred_q     <= data_cred_d;
      data_cred_cnt_q <= data_cred_cnt_d;
      len_err_q       <= len_err_d;
    end
  end

  assign tx_data_o           = tx_data_q;
  assign tx_valid_o          = tx_valid_q;
  assign tx_sop_o            = sop_q;
  assign tx_eop_o            = eop_q;
  assign tx_dw_en_o          = dw_en_q;
  assign hdr_cred_consume_o  = hdr_cred_q;
  assign data_cred_consume_o = data_cred_q;
  assign data_cred_cnt_o     = data_cred_cnt_q;
  assign len_err_o           = len_err_q;

`ifdef TL_CPL_TX_STATS_EN
  logic [CNT_W-1:0] cpl_cnt_q, cpl_cnt_d;
  logic [CNT_W-1:0] cpld_cnt_q, cpld_cnt_d;
  logic             eop_taken;

  // An EOP beat that is also SOP can only be a header-only Cpl.
  assign eop_taken = tx_valid_q && tx_ready_i && eop_q;

  always_comb begin
    cpl_cnt_d  = cpl_cnt_q;
    cpld_cnt_d = cpld_cnt_q;
    if (eop_taken && sop_q) begin
      cpl_cnt_d = cpl_cnt_q + 1'b1;
    end
    if (eop_taken && !sop_q) begin
      cpld_cnt_d = cpld_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpl_cnt_q  <= '0;
      cpld_cnt_q <= '0;
    end else begin
      cpl_cnt_q  <= cpl_cnt_d;
      cpld_cnt_q <= cpld_cnt_d;
    end
  end

  assign cpl_cnt_o  = cpl_cnt_q;
  assign cpld_cnt_o = cpld_cnt_q;
`else
  assign cpl_cnt_o  = '0;
  assign cpld_cnt_o = '0;
`endif

endmodule

// File: doc/tl_cpl_tx_packer.md
# tl_cpl_tx_packer

Transmit-side packer directly downstream of the completion generator. Accepts one 128-bit completion header and, for CplD, a stream of 256-bit payload beats. Serializes them into the transaction-layer TX beat stream (header beat, then payload beats) with SOP/EOP and per-DW enables. Emits flow-control credit consumption pulses toward the credit manager.

## Interface
- MAX_PAYLOAD_DW, 256: largest legal CplD length in DW; longer headers raise `len_err_o`.
- CNT_W, 32: width of statistics counters (only with `TL_CPL_TX_STATS_EN`).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cpl_hdr_i  in  128  3DW header; DW0 = [127:96], DW1 = [95:64], DW2 = [63:32], [31:0] ignored.
- cpl_hdr_valid_i / cpl_hdr_ready_o  in/out  1  header handshake.
- cpl_data_i  in  256  payload beat; DW0 of the beat = [255:224].
- cpl_data_valid_i / cpl_data_ready_o  in/out  1  payload handshake.
- tx_data_o  out  256  output beat.
- tx_valid_o / tx_ready_i  out/in  1  output handshake.
- tx_sop_o, tx_eop_o  out  1  first/last beat of a TLP.
- tx_dw_en_o  out  8  bit 7 = DW at [255:224], bit 0 = DW at [31:0].
- hdr_cred_consume_o  out  1  one-cycle pulse, one header credit used.
- data_cred_consume_o  out  1  one-cycle pulse, data credits used.
- data_cred_cnt_o  out  9  data credits (4-DW units) consumed, valid with the pulse.
- len_err_o  out  1  one-cycle pulse, length exceeds MAX_PAYLOAD_DW.
- cpl_cnt_o, cpld_cnt_o  out  CNT_W  packets sent (macro only).

## Operation
- has_data = cpl_hdr_i[126] (Fmt bit). len = cpl_hdr_i[105:96], with 0 meaning 1024.
- Output stage is a single register. `adv = !tx_valid_o || tx_ready_i`.
- FSM states:
  - IDLE: `cpl_hdr_ready_o = adv`. On a header handshake:
    - load `tx_data_o = {hdr[127:32], 160'b0}`, sop = 1, dw_en = 8'hE0, eop = !has_data, tx_valid_o = 1.
    - pulse hdr_cred_consume_o.
    - if has_data: pulse data_cred_consume_o with data_cred_cnt_o = ceil(len/4), set rem = len (11 bits), go to DATA.
    - if has_data and len > MAX_PAYLOAD_DW: additionally pulse len_err_o; the packet is still forwarded unchanged.
  - DATA: `cpl_data_ready_o = adv`. On a data handshake:
    - load tx_data_o = cpl_data_i, sop = 0.
    - dw_en = 8'hFF if rem ≥ 8, else the top rem bits set (e.g. rem = 3 gives 8'hE0).
    - eop = (rem ≤ 8); rem -= 8; on eop return to IDLE.
- When adv is true and no handshake occurs, tx_valid_o clears to 0.
- Ready outputs are combinational from state, tx_valid_o and tx_ready_i. No valid-to-ready path exists.
- cpl_hdr_ready_o = 0 in DATA and cpl_data_ready_o = 0 in IDLE. A header is never accepted mid-packet.

## Timing
- Reset values: tx_valid_o, sop, eop, all pulses = 0; tx_data_o = 0; tx_dw_en_o = 0; counters = 0; state IDLE, rem = 0.
- Latency: input handshake at cycle N gives the output beat valid at N+1. Credit pulses are asserted in cycle N+1, one cycle wide.
- Full throughput: one beat per cycle when tx_ready_i = 1 and the source is valid.
- Backpressure: while tx_valid_o && !tx_ready_i, tx_data_o, sop, eop and dw_en hold stable, and no input is accepted.
- Simultaneous: the final data beat and the next header can be accepted on consecutive cycles only. The IDLE header accept is allowed in the same cycle as the last beat draining (adv = 1).
- Reset mid-packet: return to IDLE immediately. The partial TLP is abandoned; no EOP is emitted.
- len = 1024: rem reaches 0 after 128 beats; data_cred_cnt_o = 256.

## Configuration
- `TL_CPL_TX_STATS_EN` defined:
  - cpl_cnt_o increments on each EOP beat accepted by the sink (tx_valid_o && tx_ready_i && tx_eop_o) for a Cpl.
  - cpld_cnt_o does the same for a CplD.
  - Both counters wrap at 2^CNT_W.
- Not defined: both counters are tied to 0 and no counter flops exist.

## Test plan
- Cpl, hdr[127:120] = 8'h0A, tx_ready_i = 1 → one beat at N+1 with sop = eop = 1, dw_en = 8'hE0; hdr_cred pulse; no data_cred pulse.
- CplD len = 1 (hdr[127:120] = 8'h4A) → header beat (eop = 0), then one data beat with dw_en = 8'h80, eop = 1; data_cred_cnt_o = 1.
- CplD len = 19 → three data beats with dw_en FF, FF, E0; eop on the third; data_cred_cnt_o = 5.
- CplD len = 16, tx_ready_i low for 5 cycles on beat 2 → beat 2 is held bit-stable, both input readies = 0, no beat is lost or duplicated.
- CplD len = 0 with MAX_PAYLOAD_DW = 256 → len_err_o pulse, 128 data beats, data_cred_cnt_o = 256.
- rst_n asserted after beat 1 of a len = 16 CplD → all outputs return to 0; a following Cpl header completes normally. With the macro defined, 3 Cpl + 2 CplD sent gives cpl_cnt_o = 3, cpld_cnt_o = 2.
